// File: rtl/prog_loader_mem_if.sv
// Shared types and the bundle of fetch and loader-stream signals between the CPU/loader side and prog_loader_mem.
// The package lives here so the interface and the memory agree on the address and data layouts.
package prog_loader_pkg;
   typedef struct packed {
      logic [0:0] mode;
      logic [3:0] addr;
   } virt_addr_t;

   typedef struct packed {
      virt_addr_t virt_addr;
   } addr_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] imm;
   } data_t;
endpackage

interface prog_loader_mem_if #(parameter int NBANKS = 2);
   import prog_loader_pkg::*;

   addr_t             addr;
   data_t             data;
   logic              ld_valid;
   logic [7:0]        ld_byte;
   logic              ld_ready;
   logic              ld_abort;
   logic              busy;
   logic              done;
   logic              error;
   logic [NBANKS-1:0] bank_valid;

   modport master (
      output addr, ld_valid, ld_byte, ld_abort,
      input  data, ld_ready, busy, done, error, bank_valid
   );

   modport slave (
      input  addr, ld_valid, ld_byte, ld_abort,
      output data, ld_ready, busy, done, error, bank_valid
   );
endinterface

// File: rtl/prog_loader_mem.sv
// Banked instruction memory with an asynchronous fetch port.
// A byte-stream loader stages an image, verifies its checksum and commits it atomically into one bank.
module prog_loader_mem
   import prog_loader_pkg::*;
#(
   parameter int         NBANKS    = 2,
   parameter logic [7:0] FILL_WORD = 8'h00
) (
   input logic               clock,
   input logic               reset,
   prog_loader_mem_if.slave  bus
);

   localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

   typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, COMMIT} state_t;

   state_t            state;
   logic              ld_ready_r;
   logic              busy_r;
   logic              done_r;
   logic              error_r;
   logic [NBANKS-1:0] bank_valid_r;
   logic [7:0]        sum;
   logic [BW-1:0]     bank_r;
   logic [3:0]        start_r;
   logic [3:0]        cnt;
   logic [3:0]        idx;
   logic [15:0]       stage_mask;
   data_t             stage [16];
   data_t             mem [NBANKS][16];

   logic xfer;
   logic abort_now;
   logic hdr_bad;
   logic [7:0] sum_next;

   assign xfer      = bus.ld_valid && ld_ready_r;
   assign abort_now = bus.ld_abort && (state != COMMIT);
   assign hdr_bad   = (bus.ld_byte[6:4] != 3'b000) || ({7'd0, bus.ld_byte[7]} >= 8'(NBANKS));
   assign sum_next  = sum + bus.ld_byte;

   assign bus.ld_ready   = ld_ready_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.error      = error_r;
   assign bus.bank_valid = bank_valid_r;
   assign bus.data       = bank_valid_r[bus.addr.virt_addr.mode]
                           ? mem[bus.addr.virt_addr.mode][bus.addr.virt_addr.addr]
                           : data_t'(FILL_WORD);

   // Loader control: one byte per transfer; abort wins over a transfer except during the commit cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         ld_ready_r   <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         bank_valid_r <= '0;
         sum          <= 8'h00;
      end else begin
         done_r <= 1'b0;
         if (abort_now) begin
            state      <= IDLE;
            busy_r     <= 1'b0;
            ld_ready_r <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (xfer) begin
                     if (hdr_bad) begin
                        error_r <= 1'b1;
                     end else begin
                        bank_r  <= BW'(bus.ld_byte[7]);
                        start_r <= bus.ld_byte[3:0];
                        sum     <= bus.ld_byte;
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= LEN;
                     end
                  end
               end
               LEN: begin
                  if (xfer) begin
                     sum <= sum_next;
                     if (bus.ld_byte[7:4] != 4'h0) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                     end else begin
                        cnt   <= bus.ld_byte[3:0];
                        idx   <= 4'h0;
                        state <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (xfer) begin
                     sum <= sum_next;
                     idx <= idx + 4'h1;
                     if (idx == cnt) state <= CHK;
                  end
               end
               CHK: begin
                  if (xfer) begin
                     sum <= sum_next;
                     if (sum_next == 8'h00) begin
                        state      <= COMMIT;
                        ld_ready_r <= 1'b0;
                     end else begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                     end
                  end
               end
               COMMIT: begin
                  bank_valid_r[bank_r] <= 1'b1;
                  done_r     <= 1'b1;
                  busy_r     <= 1'b0;
                  ld_ready_r <= 1'b1;
                  state      <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Staging buffer and bank storage carry no reset; unmasked words keep whatever they held.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (!abort_now && xfer && state == LEN) begin
            stage_mask <= '0;
         end
         if (!abort_now && xfer && state == DATA) begin
            stage[start_r + idx]      <= data_t'(bus.ld_byte);
            stage_mask[start_r + idx] <= 1'b1;
         end
         if (state == COMMIT) begin
            for (int i = 0; i < 16; i++) begin
               if (stage_mask[i]) mem[bank_r][i] <= stage[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_loader_mem.sv
// Scoreboard bench for prog_loader_mem: stimulus pushes expected observations, a negedge monitor pops and compares.
// Frames are hand-written directed vectors; expected memory words are hand-derived constants.
module tb_prog_loader_mem;
   import prog_loader_pkg::*;

   localparam int SEL_DATA = 0, SEL_BV = 1, SEL_ERR = 2, SEL_BUSY = 3,
                  SEL_DONE = 4, SEL_RDY = 5, SEL_DCNT = 6;

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] exp;
   } chk_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checksTotal = 0;
   int   checksPassed = 0;
   int   doneCount = 0;
   int   expDone = 0;
   chk_t sb[$];

   prog_loader_mem_if #(.NBANKS(2)) bus();

   prog_loader_mem #(.NBANKS(2), .FILL_WORD(8'h00)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Monitor: counts done pulses and checks every queued expectation against the settled outputs.
   always @(negedge clock) begin
      chk_t c;
      logic [7:0] act;
      if (bus.done === 1'b1) doneCount++;
      while (sb.size() > 0) begin
         c = sb.pop_front();
         case (c.sel)
            SEL_DATA: act = bus.data;
            SEL_BV:   act = 8'(bus.bank_valid);
            SEL_ERR:  act = 8'(bus.error);
            SEL_BUSY: act = 8'(bus.busy);
            SEL_DONE: act = 8'(bus.done);
            SEL_RDY:  act = 8'(bus.ld_ready);
            default:  act = 8'(doneCount);
         endcase
         checksTotal++;
         if (act === c.exp) checksPassed++;
         else $display("[TB] FAIL %s: got %02h expected %02h", c.name, act, c.exp);
      end
   end

   task automatic checkOutput(input string name, input int sel, input logic [7:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      sb.push_back(c);
   endtask

   task automatic checkFetch(input logic [4:0] a, input logic [7:0] exp);
      bus.addr = a;
      checkOutput($sformatf("fetch_%02h", a), SEL_DATA, exp);
      @(posedge clock); #1;
   endtask

   // Present one byte and hold it until the memory accepts it.
   task automatic applyStimulus(input logic [7:0] b);
      int n = 0;
      bus.ld_valid = 1'b1;
      bus.ld_byte  = b;
      while (!bus.ld_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= 20) begin
         checksTotal++;
         $display("[TB] FAIL ld_ready_timeout: got 0 expected 1");
      end
      @(posedge clock); #1;
      bus.ld_valid = 1'b0;
   endtask

   task automatic sendFrame(input logic bank, input logic [3:0] start, input int n,
                            input logic [7:0] base, input logic [7:0] step, input bit bad);
      logic [7:0] s, b;
      b = {bank, 3'b000, start};
      s = b;
      applyStimulus(b);
      checkOutput("hdr_error_clear", SEL_ERR, 8'h00);
      checkOutput("hdr_busy", SEL_BUSY, 8'h01);
      b = {4'h0, 4'(n - 1)};
      s = s + b;
      applyStimulus(b);
      for (int i = 0; i < n; i++) begin
         b = base + 8'(i) * step;
         s = s + b;
         applyStimulus(b);
      end
      b = 8'h00 - s + (bad ? 8'h01 : 8'h00);
      applyStimulus(b);
   endtask

   task automatic commitChecks(input logic [7:0] bv);
      checkOutput("commit_done_low", SEL_DONE, 8'h00);
      checkOutput("commit_busy", SEL_BUSY, 8'h01);
      checkOutput("commit_ready_low", SEL_RDY, 8'h00);
      @(posedge clock); #1;
      expDone++;
      checkOutput("done_pulse", SEL_DONE, 8'h01);
      checkOutput("done_busy_low", SEL_BUSY, 8'h00);
      checkOutput("done_ready", SEL_RDY, 8'h01);
      checkOutput("done_count", SEL_DCNT, 8'(expDone));
      checkOutput("bank_valid", SEL_BV, bv);
      @(posedge clock); #1;
      checkOutput("done_one_cycle", SEL_DONE, 8'h00);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bus.addr     = '0;
      bus.ld_valid = 1'b0;
      bus.ld_byte  = 8'h00;
      bus.ld_abort = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state and fill word everywhere
      checkOutput("rst_bank_valid", SEL_BV, 8'h00);
      checkOutput("rst_ready", SEL_RDY, 8'h01);
      checkOutput("rst_busy", SEL_BUSY, 8'h00);
      checkOutput("rst_error", SEL_ERR, 8'h00);
      for (int a = 0; a < 32; a++) checkFetch(5'(a), 8'h00);

      // Bank0 full image 00..0F
      sendFrame(1'b0, 4'h0, 16, 8'h00, 8'h01, 1'b0);
      commitChecks(8'h01);
      for (int i = 0; i < 16; i++) checkFetch({1'b0, 4'(i)}, 8'(i));
      checkFetch(5'h10, 8'h00);

      // Bank1 full image 50..5F, then a wrapping partial load
      sendFrame(1'b1, 4'h0, 16, 8'h50, 8'h01, 1'b0);
      commitChecks(8'h03);
      sendFrame(1'b1, 4'hE, 3, 8'hA1, 8'h11, 1'b0);
      commitChecks(8'h03);
      checkFetch(5'h1E, 8'hA1);
      checkFetch(5'h1F, 8'hB2);
      checkFetch(5'h10, 8'hC3);
      checkFetch(5'h11, 8'h51);
      checkFetch(5'h1D, 8'h5D);
      checkFetch(5'h0E, 8'h0E);

      // Bad checksum leaves the bank alone
      sendFrame(1'b0, 4'h2, 2, 8'hEE, 8'h00, 1'b1);
      checkOutput("badchk_error", SEL_ERR, 8'h01);
      checkOutput("badchk_busy", SEL_BUSY, 8'h00);
      checkOutput("badchk_ready", SEL_RDY, 8'h01);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("badchk_no_done", SEL_DCNT, 8'(expDone));
      checkOutput("badchk_bank_valid", SEL_BV, 8'h03);
      checkFetch(5'h02, 8'h02);
      checkFetch(5'h03, 8'h03);
      sendFrame(1'b0, 4'h4, 1, 8'h44, 8'h00, 1'b0);
      commitChecks(8'h03);
      checkFetch(5'h04, 8'h44);
      checkFetch(5'h05, 8'h05);

      // Reserved header bit rejected, next frame still loads
      applyStimulus(8'h10);
      checkOutput("hdr10_error", SEL_ERR, 8'h01);
      checkOutput("hdr10_busy", SEL_BUSY, 8'h00);
      checkOutput("hdr10_ready", SEL_RDY, 8'h01);
      sendFrame(1'b0, 4'h8, 2, 8'h81, 8'h01, 1'b0);
      commitChecks(8'h03);
      checkFetch(5'h08, 8'h81);
      checkFetch(5'h09, 8'h82);
      checkFetch(5'h0A, 8'h0A);

      // Abort mid-DATA with a byte offered in the same cycle
      applyStimulus(8'h80);
      applyStimulus(8'h03);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      bus.ld_abort = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_byte  = 8'h33;
      @(posedge clock); #1;
      bus.ld_abort = 1'b0;
      bus.ld_valid = 1'b0;
      checkOutput("abort_busy", SEL_BUSY, 8'h00);
      checkOutput("abort_ready", SEL_RDY, 8'h01);
      checkOutput("abort_error", SEL_ERR, 8'h00);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("abort_no_done", SEL_DCNT, 8'(expDone));
      checkFetch(5'h10, 8'hC3);
      checkFetch(5'h11, 8'h51);
      checkFetch(5'h12, 8'h52);

      // Reset mid-frame invalidates every bank
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      applyStimulus(8'h99);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checkOutput("midrst_bank_valid", SEL_BV, 8'h00);
      checkOutput("midrst_busy", SEL_BUSY, 8'h00);
      checkOutput("midrst_ready", SEL_RDY, 8'h01);
      checkFetch(5'h05, 8'h00);
      checkFetch(5'h1E, 8'h00);
      sendFrame(1'b1, 4'h3, 1, 8'h3C, 8'h00, 1'b0);
      commitChecks(8'h02);
      checkFetch(5'h13, 8'h3C);
      checkFetch(5'h03, 8'h00);

      repeat (3) @(posedge clock);
      if (sb.size() != 0) begin
         checksTotal++;
         $display("[TB] FAIL scoreboard_drain: got %0d expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
